// File: rtl/raster_split_scheduler_if.sv
// Bundle between CPU decode / PPU scanline counter and the raster split scheduler.
// Carries register writes, frame/line events in; CHR bank, IRQ, index, busy out.
interface raster_split_scheduler_if #(
  parameter int BANK_W = 5,
  parameter int LINE_W = 8,
  parameter int IDX_W  = 2
);
  logic              reg_we;
  logic [3:0]        reg_addr;
  logic [7:0]        reg_wdata;
  logic              frame_start;
  logic              line_tick;
  logic [LINE_W-1:0] line;
  logic [BANK_W-1:0] chr_bank;
  logic              irq;
  logic [IDX_W-1:0]  active_idx;
  logic              busy;

  modport master (
    output reg_we, reg_addr, reg_wdata,
    output frame_start, line_tick, line,
    input  chr_bank, irq, active_idx, busy
  );

  modport slave (
    input  reg_we, reg_addr, reg_wdata,
    input  frame_start, line_tick, line,
    output chr_bank, irq, active_idx, busy
  );
endinterface

// File: rtl/raster_split_scheduler.sv
// Per-frame CHR bank sequencer and raster IRQ scheduler.
// Ports: m2 clock, reset (sync, high), bus = slave side of raster_split_scheduler_if.
module raster_split_scheduler #(
  parameter  int ENTRIES = 4,
  parameter  int BANK_W  = 5,
  parameter  int LINE_W  = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input logic                     m2,
  input logic                     reset,
  raster_split_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ARMED,
    DONE
  } state_t;

  logic [LINE_W-1:0] line_tab [ENTRIES];
  logic [BANK_W-1:0] bank_tab [ENTRIES];
  logic              irq_tab  [ENTRIES];
  logic              enable;
  logic [2:0]        cnt_m1;
  logic [BANK_W-1:0] base;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [BANK_W-1:0] cur, cur_nxt;
  logic              irq_q, irq_nxt;

  logic [IDX_W-1:0]  wsel;
  logic              wr_line, wr_bank;
  logic              wr_ctrl, wr_base, wr_ack;
  logic [3:0]        cnt_raw, count, idx_ext;
  logic              hit;

  assign wsel    = bus.reg_addr[IDX_W-1:0];
  assign wr_ctrl = bus.reg_we && (bus.reg_addr == 4'hC);
  assign wr_base = bus.reg_we && (bus.reg_addr == 4'hD);
  assign wr_ack  = bus.reg_we && (bus.reg_addr == 4'hE);
  assign wr_line = bus.reg_we && !bus.reg_addr[3]
                && (int'(bus.reg_addr[2:0]) < ENTRIES);
  // 0xC..0xF are reserved for control even when the table is 8 deep
  assign wr_bank = bus.reg_we && bus.reg_addr[3]
                && (bus.reg_addr[3:2] != 2'b11)
                && (int'(bus.reg_addr[2:0]) < ENTRIES);

  assign cnt_raw = {1'b0, cnt_m1} + 4'd1;
  assign count   = (cnt_raw > 4'(ENTRIES)) ? 4'(ENTRIES) : cnt_raw;
  assign idx_ext = 4'(idx);

  // frame_start suppresses a coincident tick; idx beyond count never fires
  assign hit = (state == ARMED) && bus.line_tick && !bus.frame_start
            && (idx_ext < count) && (bus.line == line_tab[idx]);

  always_ff @(posedge m2) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        line_tab[i] <= '0;
        bank_tab[i] <= '0;
        irq_tab[i]  <= 1'b0;
      end
      enable <= 1'b0;
      cnt_m1 <= '0;
      base   <= '0;
    end else begin
      if (wr_line) line_tab[wsel] <= LINE_W'(bus.reg_wdata);
      if (wr_bank) begin
        bank_tab[wsel] <= BANK_W'(bus.reg_wdata);
        irq_tab[wsel]  <= bus.reg_wdata[7];
      end
      if (wr_ctrl) begin
        enable <= bus.reg_wdata[0];
        cnt_m1 <= bus.reg_wdata[3:1];
      end
      if (wr_base) base <= BANK_W'(bus.reg_wdata);
    end
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cur   <= '0;
      irq_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cur   <= cur_nxt;
      irq_q <= irq_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cur_nxt   = cur;
    irq_nxt   = irq_q;

    // set beats ack
    if (wr_ack) irq_nxt = 1'b0;
    if (hit && irq_tab[idx]) irq_nxt = 1'b1;

    case (state)
      ARMED: begin
        if (hit) begin
          cur_nxt = bank_tab[idx];
          if (idx_ext + 4'd1 == count) state_nxt = DONE;
          else idx_nxt = idx + 1'b1;
        end else if (idx_ext >= count) begin
          state_nxt = DONE;
        end
      end
      default: ;
    endcase

    if (enable && bus.frame_start) begin
      state_nxt = ARMED;
      idx_nxt   = '0;
      cur_nxt   = base;
    end

    if (wr_ctrl) begin
      if (!bus.reg_wdata[0]) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end else if (!enable) begin
        state_nxt = WAIT;
        cur_nxt   = base;
      end
    end
  end

  assign bus.chr_bank   = (state == IDLE) ? base : cur;
  assign bus.irq        = irq_q;
  assign bus.active_idx = idx;
  assign bus.busy       = (state == ARMED);

endmodule

// File: tb/tb_raster_split_scheduler.sv
// Testbench for raster_split_scheduler: directed steps then random traffic.
// Every cycle is compared against a behavioural model of the frame walk.
module tb_raster_split_scheduler;
  localparam int ENTRIES = 4;
  localparam int BANK_W  = 5;
  localparam int LINE_W  = 8;
  localparam int IDX_W   = 2;

  logic m2 = 1'b0;
  logic reset;

  raster_split_scheduler_if #(
    .BANK_W(BANK_W), .LINE_W(LINE_W), .IDX_W(IDX_W)
  ) bus ();

  raster_split_scheduler #(
    .ENTRIES(ENTRIES), .BANK_W(BANK_W), .LINE_W(LINE_W)
  ) dut (
    .m2   (m2),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 m2 = ~m2;

  int n_chk = 0;
  int n_fail = 0;

  int m_line [ENTRIES];
  int m_bk   [ENTRIES];
  bit m_ie   [ENTRIES];
  bit m_en, m_frame, m_done, m_irq;
  int m_cnt, m_base, m_bank, m_idx;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(bit we, logic [3:0] a, logic [7:0] d,
                       bit fs, bit tk, logic [7:0] ln);
    bit hit;
    int ob;
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_line[i] = 0; m_bk[i] = 0; m_ie[i] = 0;
      end
      m_en = 0; m_frame = 0; m_done = 0; m_irq = 0;
      m_cnt = 1; m_base = 0; m_bank = 0; m_idx = 0;
      return;
    end
    hit = m_en && m_frame && !m_done && (m_idx < m_cnt)
       && tk && !fs && (int'(ln) == m_line[m_idx]);
    if (we && a == 4'hE) m_irq = 0;
    if (hit && m_ie[m_idx]) m_irq = 1;
    ob = m_base;
    if (hit) begin
      m_bank = m_bk[m_idx];
      if (m_idx + 1 == m_cnt) m_done = 1;
      else m_idx++;
    end else if (m_en && m_frame && !m_done && m_idx >= m_cnt) begin
      m_done = 1;
    end
    if (m_en && fs) begin
      m_frame = 1; m_done = 0; m_idx = 0; m_bank = ob;
    end
    if (we) begin
      if (int'(a) < ENTRIES) begin
        m_line[a] = int'(d);
      end else if (a >= 8 && int'(a) < 8 + ENTRIES) begin
        m_bk[a-8] = int'(d) % 32;
        m_ie[a-8] = d[7];
      end else if (a == 4'hC) begin
        m_cnt = ((int'(d) >> 1) & 7) + 1;
        if (m_cnt > ENTRIES) m_cnt = ENTRIES;
        if (!d[0]) begin
          m_en = 0; m_frame = 0; m_done = 0; m_idx = 0;
        end else if (!m_en) begin
          m_en = 1; m_frame = 0; m_done = 0; m_bank = ob;
        end
      end else if (a == 4'hD) begin
        m_base = int'(d) % 32;
      end
    end
  endtask

  task automatic cyc(bit we, logic [3:0] a, logic [7:0] d,
                     bit fs, bit tk, logic [7:0] ln);
    bus.reg_we      = we;
    bus.reg_addr    = a;
    bus.reg_wdata   = d;
    bus.frame_start = fs;
    bus.line_tick   = tk;
    bus.line        = ln;
    model(we, a, d, fs, tk, ln);
    @(posedge m2);
    #1;
    chk("chr_bank", 32'(bus.chr_bank), m_en ? m_bank : m_base);
    chk("irq", 32'(bus.irq), 32'(m_irq));
    chk("busy", 32'(bus.busy), 32'(m_en && m_frame && !m_done));
    chk("active_idx", 32'(bus.active_idx), m_idx);
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    cyc(1'b1, a, d, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic tick(int l);
    cyc(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 8'(l));
  endtask

  task automatic fstart();
    cyc(1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 8'd0);
  endtask

  int lc;
  bit r_we, r_fs, r_tk;
  logic [3:0] r_a;
  logic [7:0] r_d;

  initial begin
    reset = 1'b1;
    fstart();
    fstart();
    reset = 1'b0;
    chk("rst_bank", 32'(bus.chr_bank), 0);

    // main frame walk
    wr(4'h0, 8'd64);  wr(4'h8, 8'h05);
    wr(4'h1, 8'd128); wr(4'h9, 8'h89);
    wr(4'h2, 8'd192); wr(4'hA, 8'h03);
    wr(4'hD, 8'h01);
    wr(4'hC, 8'h05);
    fstart();
    for (int l = 0; l < 240; l++) begin
      tick(l);
      if (l == 63)  chk("t2_before64", 32'(bus.chr_bank), 1);
      if (l == 64)  chk("t2_at64", 32'(bus.chr_bank), 5);
      if (l == 127) chk("t2_irq_before", 32'(bus.irq), 0);
      if (l == 128) chk("t2_at128", 32'(bus.chr_bank), 9);
      if (l == 128) chk("t2_irq_at128", 32'(bus.irq), 1);
      if (l == 192) chk("t2_at192", 32'(bus.chr_bank), 3);
    end
    chk("t2_done_busy", 32'(bus.busy), 0);

    // ack coincident with a new irq match
    fstart();
    for (int l = 0; l < 128; l++) tick(l);
    cyc(1'b1, 4'hE, 8'h00, 1'b0, 1'b1, 8'd128);
    chk("t3_set_wins", 32'(bus.irq), 1);
    for (int l = 129; l < 240; l++) tick(l);
    wr(4'hE, 8'h00);
    chk("t3_ack", 32'(bus.irq), 0);

    // out-of-order lines: second entry never fires
    wr(4'h0, 8'd100);
    wr(4'h1, 8'd50);
    wr(4'hC, 8'h03);
    fstart();
    for (int l = 0; l < 240; l++) tick(l);
    chk("t4_bank", 32'(bus.chr_bank), 5);
    chk("t4_busy", 32'(bus.busy), 1);
    fstart();
    chk("t4_restore", 32'(bus.chr_bank), 1);
    chk("t4_idx", 32'(bus.active_idx), 0);

    // frame_start beats a coincident tick
    wr(4'h8, 8'h85);
    wr(4'h0, 8'd0);
    cyc(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd0);
    chk("t5_bank", 32'(bus.chr_bank), 1);
    chk("t5_idx", 32'(bus.active_idx), 0);
    tick(0);
    chk("t5_fire", 32'(bus.chr_bank), 5);

    // disable mid-frame keeps pending irq
    wr(4'hC, 8'h02);
    chk("t6_bank", 32'(bus.chr_bank), 1);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_irq", 32'(bus.irq), 1);

    // reset mid-frame
    wr(4'hC, 8'h03);
    fstart();
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("t1_irq", 32'(bus.irq), 0);
    fstart();
    chk("t1_fs_ignored", 32'(bus.busy), 0);
    wr(4'hC, 8'h03);
    fstart();
    chk("t1_rearm", 32'(bus.busy), 1);

    // random traffic
    lc = 0;
    repeat (3000) begin
      r_we = ($urandom % 8) == 0;
      r_a  = 4'($urandom % 16);
      r_d  = 8'($urandom);
      if (r_a < 4) r_d = 8'($urandom_range(0, 39));
      if (r_a == 4'hC) r_d[0] = ($urandom % 4) != 0;
      r_fs = ($urandom % 97) == 0;
      r_tk = ($urandom % 2) == 1;
      if (r_fs) lc = 0;
      cyc(r_we, r_a, r_d, r_fs, r_tk, 8'(lc));
      if (r_tk && !r_fs) lc = (lc + 1) % 40;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
